// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the MIPS hazard sequencer: forwarding selects,
// MDU state encoding and the hard-wired zero register.
package hazard_sequencer_pkg;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_REG = 2'b00;
   localparam fwd_sel_t FWD_WB  = 2'b01;
   localparam fwd_sel_t FWD_MEM = 2'b10;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // A later stage can supply a source only if it writes a real (non-$0) register.
   function automatic logic reg_match(input logic       reg_write,
                                      input logic [4:0] dest,
                                      input logic [4:0] src);
      return reg_write && (dest != REG_ZERO) && (dest == src);
   endfunction

endpackage

// File: rtl/hazard_sequencer_forward_unit.sv
// ALU operand forwarding select for one source register; MEM beats WB.
module forward_unit
   import hazard_sequencer_pkg::*;
(
   input  logic [4:0] src_reg,
   input  logic [4:0] ex_mem_dest,
   input  logic       ex_mem_reg_write,
   input  logic [4:0] mem_wb_dest,
   input  logic       mem_wb_reg_write,
   output fwd_sel_t   fwd_sel
);

   always_comb begin
      fwd_sel = FWD_REG;
      if (reg_match(ex_mem_reg_write, ex_mem_dest, src_reg)) begin
         fwd_sel = FWD_MEM;
      end else if (reg_match(mem_wb_reg_write, mem_wb_dest, src_reg)) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage MIPS pipeline: stalls, flushes, forwarding
// and HI/LO busy timing. Define HAZARD_STATS_EN to add saturating statistics counters.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int MDU_LATENCY = 4,
   parameter int CNT_W       = 32
)(
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic [4:0]       IF_ID_Rs,
   input  logic [4:0]       IF_ID_Rt,
   input  logic             IF_ID_UsesRt,
   input  logic             IF_ID_ReadsHILO,
   input  logic [4:0]       ID_EX_Rs,
   input  logic [4:0]       ID_EX_Rt,
   input  logic             ID_EX_MemRead,
   input  logic             ID_EX_MDU_Start,
   input  logic [4:0]       EX_MEM_Dest,
   input  logic             EX_MEM_RegWrite,
   input  logic [4:0]       MEM_WB_Dest,
   input  logic             MEM_WB_RegWrite,
   input  logic             Branch_Taken,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Bubble,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Flush,
   output logic [1:0]       ForwardA,
   output logic [1:0]       ForwardB,
   output logic             HILO_Busy,
   output logic             HILO_Write
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count,
   output logic [CNT_W-1:0] HILO_Wait_Count
`endif
);

   localparam logic [3:0] MDU_RELOAD = 4'(MDU_LATENCY - 1);

   logic [0:0] state;
   logic [0:0] state_next;
   logic [3:0] mdu_cnt;
   logic [3:0] mdu_cnt_next;
   logic       load_use;
   logic       hilo_use;
   logic       stall;
   logic       mdu_issue;

   forward_unit u_forward_a (
      .src_reg          (ID_EX_Rs),
      .ex_mem_dest      (EX_MEM_Dest),
      .ex_mem_reg_write (EX_MEM_RegWrite),
      .mem_wb_dest      (MEM_WB_Dest),
      .mem_wb_reg_write (MEM_WB_RegWrite),
      .fwd_sel          (ForwardA)
   );

   forward_unit u_forward_b (
      .src_reg          (ID_EX_Rt),
      .ex_mem_dest      (EX_MEM_Dest),
      .ex_mem_reg_write (EX_MEM_RegWrite),
      .mem_wb_dest      (MEM_WB_Dest),
      .mem_wb_reg_write (MEM_WB_RegWrite),
      .fwd_sel          (ForwardB)
   );

   assign load_use = ID_EX_MemRead && (ID_EX_Rt != REG_ZERO) &&
                     ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
   // HI/LO becomes readable in the final busy cycle because forwarding covers the write.
   assign hilo_use = (state == BUSY) && (mdu_cnt != 4'd0) && IF_ID_ReadsHILO;
   assign stall    = load_use || hilo_use;

   // A taken branch overrides any stall so the wrong-path instructions drain.
   always_comb begin
      IF_ID_Flush  = Branch_Taken;
      ID_EX_Flush  = Branch_Taken;
      EX_MEM_Flush = Branch_Taken;
      PC_Write     = Branch_Taken || !stall;
      IF_ID_Write  = Branch_Taken || !stall;
      ID_EX_Bubble = !Branch_Taken && stall;
   end

   assign HILO_Busy  = (state == BUSY);
   assign HILO_Write = (state == BUSY) && (mdu_cnt == 4'd0);
   assign mdu_issue  = ID_EX_MDU_Start && !ID_EX_Flush;

   always_comb begin
      state_next   = state;
      mdu_cnt_next = mdu_cnt;
      case (state)
         IDLE: begin
            if (mdu_issue) begin
               state_next   = BUSY;
               mdu_cnt_next = MDU_RELOAD;
            end
         end
         BUSY: begin
            if (mdu_cnt == 4'd0) begin
               if (mdu_issue) begin
                  mdu_cnt_next = MDU_RELOAD;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               mdu_cnt_next = mdu_cnt - 4'd1;
            end
         end
         default: begin
            state_next   = IDLE;
            mdu_cnt_next = 4'd0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state   <= IDLE;
         mdu_cnt <= 4'd0;
      end else begin
         state   <= state_next;
         mdu_cnt <= mdu_cnt_next;
      end
   end

`ifdef HAZARD_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Stall_Count     <= '0;
         Flush_Count     <= '0;
         HILO_Wait_Count <= '0;
      end else begin
         if (stall && (Stall_Count != '1)) begin
            Stall_Count <= Stall_Count + CNT_ONE;
         end
         if (Branch_Taken && (Flush_Count != '1)) begin
            Flush_Count <= Flush_Count + CNT_ONE;
         end
         if (hilo_use && (HILO_Wait_Count != '1)) begin
            HILO_Wait_Count <= HILO_Wait_Count + CNT_ONE;
         end
      end
   end
`else
   logic [31:0] unused_cnt_w;
   assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (MDU_LATENCY = 4).
module tb_hazard_sequencer;

`ifdef HAZARD_STATS_EN
   localparam int STAT_W = 3;
`else
   localparam int STAT_W = 32;
`endif

   logic       Clk;
   logic       Reset_n;
   logic [4:0] IF_ID_Rs;
   logic [4:0] IF_ID_Rt;
   logic       IF_ID_UsesRt;
   logic       IF_ID_ReadsHILO;
   logic [4:0] ID_EX_Rs;
   logic [4:0] ID_EX_Rt;
   logic       ID_EX_MemRead;
   logic       ID_EX_MDU_Start;
   logic [4:0] EX_MEM_Dest;
   logic       EX_MEM_RegWrite;
   logic [4:0] MEM_WB_Dest;
   logic       MEM_WB_RegWrite;
   logic       Branch_Taken;
   logic       PC_Write;
   logic       IF_ID_Write;
   logic       ID_EX_Bubble;
   logic       IF_ID_Flush;
   logic       ID_EX_Flush;
   logic       EX_MEM_Flush;
   logic [1:0] ForwardA;
   logic [1:0] ForwardB;
   logic       HILO_Busy;
   logic       HILO_Write;
`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] Stall_Count;
   logic [STAT_W-1:0] Flush_Count;
   logic [STAT_W-1:0] HILO_Wait_Count;
`endif

   int assert_count = 0;
   int fail_count   = 0;

   hazard_sequencer #(.MDU_LATENCY(4), .CNT_W(STAT_W)) dut (
      .Clk             (Clk),
      .Reset_n         (Reset_n),
      .IF_ID_Rs        (IF_ID_Rs),
      .IF_ID_Rt        (IF_ID_Rt),
      .IF_ID_UsesRt    (IF_ID_UsesRt),
      .IF_ID_ReadsHILO (IF_ID_ReadsHILO),
      .ID_EX_Rs        (ID_EX_Rs),
      .ID_EX_Rt        (ID_EX_Rt),
      .ID_EX_MemRead   (ID_EX_MemRead),
      .ID_EX_MDU_Start (ID_EX_MDU_Start),
      .EX_MEM_Dest     (EX_MEM_Dest),
      .EX_MEM_RegWrite (EX_MEM_RegWrite),
      .MEM_WB_Dest     (MEM_WB_Dest),
      .MEM_WB_RegWrite (MEM_WB_RegWrite),
      .Branch_Taken    (Branch_Taken),
      .PC_Write        (PC_Write),
      .IF_ID_Write     (IF_ID_Write),
      .ID_EX_Bubble    (ID_EX_Bubble),
      .IF_ID_Flush     (IF_ID_Flush),
      .ID_EX_Flush     (ID_EX_Flush),
      .EX_MEM_Flush    (EX_MEM_Flush),
      .ForwardA        (ForwardA),
      .ForwardB        (ForwardB),
      .HILO_Busy       (HILO_Busy),
      .HILO_Write      (HILO_Write)
`ifdef HAZARD_STATS_EN
      ,
      .Stall_Count     (Stall_Count),
      .Flush_Count     (Flush_Count),
      .HILO_Wait_Count (HILO_Wait_Count)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic clear_inputs();
      IF_ID_Rs        = 5'd0;
      IF_ID_Rt        = 5'd0;
      IF_ID_UsesRt    = 1'b0;
      IF_ID_ReadsHILO = 1'b0;
      ID_EX_Rs        = 5'd0;
      ID_EX_Rt        = 5'd0;
      ID_EX_MemRead   = 1'b0;
      ID_EX_MDU_Start = 1'b0;
      EX_MEM_Dest     = 5'd0;
      EX_MEM_RegWrite = 1'b0;
      MEM_WB_Dest     = 5'd0;
      MEM_WB_RegWrite = 1'b0;
      Branch_Taken    = 1'b0;
   endtask

   // Inputs change 1 time unit after the active edge and are checked 1 unit later.
   task automatic next_cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      Reset_n = 1'b0;
      #2;
      assert_count++;
      if ({PC_Write, IF_ID_Write} !== 2'b11) begin
         fail_count++;
         $display("[TB] FAIL reset_write_enables: got %b expected 11", {PC_Write, IF_ID_Write});
      end
      assert_count++;
      if ({ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush} !== 4'b0000) begin
         fail_count++;
         $display("[TB] FAIL reset_flush_bubble: got %b expected 0000",
                  {ID_EX_Bubble, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush});
      end
      assert_count++;
      if ({ForwardA, ForwardB, HILO_Busy, HILO_Write} !== 6'b000000) begin
         fail_count++;
         $display("[TB] FAIL reset_fwd_hilo: got %b expected 000000",
                  {ForwardA, ForwardB, HILO_Busy, HILO_Write});
      end
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_forwarding();
      next_cycle();
      clear_inputs();
      EX_MEM_Dest = 5'd8; EX_MEM_RegWrite = 1'b1;
      MEM_WB_Dest = 5'd8; MEM_WB_RegWrite = 1'b1;
      ID_EX_Rs = 5'd8;
      #1;
      assert_count++;
      if (ForwardA !== 2'b10) begin
         fail_count++;
         $display("[TB] FAIL fwd_mem_priority: got %b expected 10", ForwardA);
      end
      EX_MEM_RegWrite = 1'b0;
      #1;
      assert_count++;
      if (ForwardA !== 2'b01) begin
         fail_count++;
         $display("[TB] FAIL fwd_wb: got %b expected 01", ForwardA);
      end
      MEM_WB_Dest = 5'd0; ID_EX_Rs = 5'd0;
      #1;
      assert_count++;
      if (ForwardA !== 2'b00) begin
         fail_count++;
         $display("[TB] FAIL fwd_zero_reg: got %b expected 00", ForwardA);
      end
      EX_MEM_Dest = 5'd8; EX_MEM_RegWrite = 1'b1;
      MEM_WB_Dest = 5'd9; MEM_WB_RegWrite = 1'b1;
      ID_EX_Rs = 5'd8; ID_EX_Rt = 5'd9;
      #1;
      assert_count++;
      if ({ForwardA, ForwardB} !== 4'b1001) begin
         fail_count++;
         $display("[TB] FAIL fwd_split_ab: got %b expected 1001", {ForwardA, ForwardB});
      end
      ID_EX_Rs = 5'd3; ID_EX_Rt = 5'd8;
      #1;
      assert_count++;
      if ({ForwardA, ForwardB} !== 4'b0010) begin
         fail_count++;
         $display("[TB] FAIL fwd_b_mem: got %b expected 0010", {ForwardA, ForwardB});
      end
   endtask

   task automatic test_load_use();
      next_cycle();
      clear_inputs();
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd9;
      #1;
      assert_count++;
      if ({PC_Write, IF_ID_Write, ID_EX_Bubble} !== 3'b001) begin
         fail_count++;
         $display("[TB] FAIL load_use_stall: got %b expected 001", {PC_Write, IF_ID_Write, ID_EX_Bubble});
      end
      next_cycle();
      ID_EX_MemRead = 1'b0; ID_EX_Rt = 5'd0;
      #1;
      assert_count++;
      if ({PC_Write, IF_ID_Write, ID_EX_Bubble} !== 3'b110) begin
         fail_count++;
         $display("[TB] FAIL load_use_release: got %b expected 110", {PC_Write, IF_ID_Write, ID_EX_Bubble});
      end
      next_cycle();
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9;
      IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd9; IF_ID_UsesRt = 1'b0;
      #1;
      assert_count++;
      if (ID_EX_Bubble !== 1'b0 || PC_Write !== 1'b1) begin
         fail_count++;
         $display("[TB] FAIL load_use_rt_unused: got bubble=%b pcw=%b expected 0 1", ID_EX_Bubble, PC_Write);
      end
      IF_ID_UsesRt = 1'b1;
      #1;
      assert_count++;
      if ({PC_Write, IF_ID_Write, ID_EX_Bubble} !== 3'b001) begin
         fail_count++;
         $display("[TB] FAIL load_use_rt_used: got %b expected 001", {PC_Write, IF_ID_Write, ID_EX_Bubble});
      end
      ID_EX_Rt = 5'd0; IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0;
      #1;
      assert_count++;
      if (ID_EX_Bubble !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL load_use_reg0: got %b expected 0", ID_EX_Bubble);
      end
   endtask

   task automatic test_branch_priority();
      next_cycle();
      clear_inputs();
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd9;
      Branch_Taken = 1'b1;
      #1;
      assert_count++;
      if ({IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PC_Write, IF_ID_Write, ID_EX_Bubble} !== 6'b111110) begin
         fail_count++;
         $display("[TB] FAIL branch_priority: got %b expected 111110",
                  {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PC_Write, IF_ID_Write, ID_EX_Bubble});
      end
      next_cycle();
      clear_inputs();
      #1;
      assert_count++;
      if ({IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush} !== 3'b000) begin
         fail_count++;
         $display("[TB] FAIL branch_clear: got %b expected 000", {IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush});
      end
   endtask

   // Start a mult, hold mfhi in ID; optionally raise a branch in busy cycle 2.
   task automatic test_mdu_timing(input logic branch_mid);
      next_cycle();
      clear_inputs();
      ID_EX_MDU_Start = 1'b1;
      #1;
      assert_count++;
      if (HILO_Busy !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL mdu_issue_cycle: busy got %b expected 0", HILO_Busy);
      end
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         ID_EX_MDU_Start = 1'b0;
         IF_ID_ReadsHILO = 1'b1;
         Branch_Taken    = branch_mid && (i == 2);
         #1;
         assert_count++;
         if (HILO_Busy !== 1'b1 || HILO_Write !== (i == 4)) begin
            fail_count++;
            $display("[TB] FAIL mdu_busy_c%0d: got busy=%b write=%b expected 1 %b", i, HILO_Busy, HILO_Write, i == 4);
         end
         if (i != 2 || !branch_mid) begin
            assert_count++;
            if (PC_Write !== (i == 4)) begin
               fail_count++;
               $display("[TB] FAIL mdu_hilo_stall_c%0d: pcw got %b expected %b", i, PC_Write, i == 4);
            end
         end
      end
      next_cycle();
      clear_inputs();
      #1;
      assert_count++;
      if ({HILO_Busy, HILO_Write} !== 2'b00) begin
         fail_count++;
         $display("[TB] FAIL mdu_done: got %b expected 00", {HILO_Busy, HILO_Write});
      end
   endtask

   task automatic test_mdu_flushed_start();
      next_cycle();
      clear_inputs();
      ID_EX_MDU_Start = 1'b1; Branch_Taken = 1'b1;
      next_cycle();
      clear_inputs();
      #1;
      assert_count++;
      if (HILO_Busy !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL mdu_flushed_start: busy got %b expected 0", HILO_Busy);
      end
   endtask

   task automatic test_back_to_back();
      next_cycle();
      clear_inputs();
      ID_EX_MDU_Start = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         next_cycle();
         ID_EX_MDU_Start = (i == 4);
         #1;
         assert_count++;
         if (HILO_Busy !== 1'b1 || HILO_Write !== (i == 4 || i == 8)) begin
            fail_count++;
            $display("[TB] FAIL b2b_c%0d: got busy=%b write=%b expected 1 %b", i, HILO_Busy, HILO_Write, i == 4 || i == 8);
         end
      end
      next_cycle();
      clear_inputs();
      #1;
      assert_count++;
      if (HILO_Busy !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL b2b_done: busy got %b expected 0", HILO_Busy);
      end
   endtask

   task automatic test_reset_mid_busy();
      next_cycle();
      clear_inputs();
      ID_EX_MDU_Start = 1'b1;
      next_cycle();
      ID_EX_MDU_Start = 1'b0;
      next_cycle();
      #1;
      Reset_n = 1'b0;
      #1;
      assert_count++;
      if ({HILO_Busy, HILO_Write} !== 2'b00) begin
         fail_count++;
         $display("[TB] FAIL reset_mid_busy: got %b expected 00", {HILO_Busy, HILO_Write});
      end
      @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         #1;
         assert_count++;
         if ({HILO_Busy, HILO_Write} !== 2'b00) begin
            fail_count++;
            $display("[TB] FAIL reset_abort_c%0d: got %b expected 00", i, {HILO_Busy, HILO_Write});
         end
      end
   endtask

`ifdef HAZARD_STATS_EN
   task automatic test_stats();
      clear_inputs();
      @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         clear_inputs();
         if (i < 3) begin
            ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd9;
         end else if (i < 5) begin
            Branch_Taken = 1'b1;
         end
      end
      #1;
      assert_count++;
      if (Stall_Count !== 3'd3 || Flush_Count !== 3'd2 || HILO_Wait_Count !== 3'd0) begin
         fail_count++;
         $display("[TB] FAIL stats_counts: got %0d %0d %0d expected 3 2 0", Stall_Count, Flush_Count, HILO_Wait_Count);
      end
      ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd9; IF_ID_Rs = 5'd9;
      repeat (7) next_cycle();
      clear_inputs();
      #1;
      assert_count++;
      if (Stall_Count !== 3'd7) begin
         fail_count++;
         $display("[TB] FAIL stats_saturate: got %0d expected 7", Stall_Count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_priority();
      test_mdu_timing(1'b0);
      test_mdu_timing(1'b1);
      test_mdu_flushed_start();
      test_back_to_back();
      test_reset_mid_busy();
`ifdef HAZARD_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Hazard controller for the 5-stage MIPS pipeline.
- Sequences the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards and produces forwarding selects for the ALU operand muxes.
- Flushes wrong-path instructions on a taken branch from EX/MEM (AND1 result).
- Owns a multi-cycle busy timer for the shared HI/LO mult/div resource.

Parameters:
- MDU_LATENCY, 4, cycles a mult/div occupies HI/LO after entering EX (legal range 1..15).
- CNT_W, 32, width of statistics counters (optional feature only).

Ports:
- Clk  in  1  pipeline clock (divided clock, Clk_out).
- Reset_n  in  1  reset; one clock; asynchronous, active-low.
- IF_ID_Rs  in  5  rs field of instruction in ID.
- IF_ID_Rt  in  5  rt field of instruction in ID.
- IF_ID_UsesRt  in  1  ID instruction reads rt as a source.
- IF_ID_ReadsHILO  in  1  ID instruction is mfhi/mflo/madd/msub.
- ID_EX_Rs  in  5  rs of instruction in EX.
- ID_EX_Rt  in  5  rt of instruction in EX.
- ID_EX_MemRead  in  1  EX instruction is a load.
- ID_EX_MDU_Start  in  1  EX instruction is mult/multu/div/divu.
- EX_MEM_Dest  in  5  destination register in MEM.
- EX_MEM_RegWrite  in  1  MEM stage writes the register file.
- MEM_WB_Dest  in  5  destination register in WB.
- MEM_WB_RegWrite  in  1  WB stage writes the register file.
- Branch_Taken  in  1  EX/MEM branch AND zero.
- PC_Write  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- ID_EX_Bubble  out  1  zero ID/EX control bits on next edge.
- IF_ID_Flush  out  1  clear IF/ID to nop.
- ID_EX_Flush  out  1  clear ID/EX control.
- EX_MEM_Flush  out  1  clear EX/MEM control.
- ForwardA  out  2  ALU A select: 00 regfile, 01 WB data, 10 MEM ALU result.
- ForwardB  out  2  same encoding for ALU B.
- HILO_Busy  out  1  mult/div in progress.
- HILO_Write  out  1  HI/LO latch enable, final busy cycle.

Behaviour:
- All outputs are combinational from registered state plus current inputs. There are no asynchronous paths from Reset_n other than clearing state.
- Reset (Reset_n=0):
  - state=IDLE, mdu_cnt=0.
  - Outputs therefore PC_Write=1, IF_ID_Write=1, all flush/bubble=0, Forward*=00, HILO_Busy=0, HILO_Write=0.
- Forwarding, ForwardA (ForwardB identical using ID_EX_Rt):
  - 10 if EX_MEM_RegWrite && EX_MEM_Dest!=0 && EX_MEM_Dest==ID_EX_Rs.
  - else 01 if MEM_WB_RegWrite && MEM_WB_Dest!=0 && MEM_WB_Dest==ID_EX_Rs.
  - else 00. MEM has priority over WB.
- load_use = ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt==IF_ID_Rt)).
- hilo_use = state==BUSY && !(mdu_cnt==0) && IF_ID_ReadsHILO.
- stall = load_use || hilo_use. When stalled: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, same cycle as detection.
- A load-use stall lasts exactly 1 cycle; the bubble removes the condition.
- Branch_Taken has top priority:
  - IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1, PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - Any stall in the same cycle is suppressed.
- MDU FSM, IDLE:
  - ID_EX_MDU_Start && !ID_EX_Flush -> BUSY, mdu_cnt=MDU_LATENCY-1.
- MDU FSM, BUSY:
  - mdu_cnt decrements each cycle. HILO_Busy=1.
  - HILO_Write=1 when mdu_cnt==0, then -> IDLE.
  - A new ID_EX_MDU_Start in the final cycle reloads the count and stays BUSY (back-to-back mult).
  - MDU_LATENCY=1: BUSY lasts one cycle, with HILO_Write in that cycle.
- Branch_Taken while BUSY: the flush does not abort the MDU; the already-issued operation completes.
- Reset_n falling mid-BUSY: aborts immediately, HILO_Write never asserts.

Optional Feature:
- HAZARD_STATS_EN defined: adds three CNT_W-bit saturating output counters.
  - Stall_Count: cycles with stall=1.
  - Flush_Count: cycles with Branch_Taken=1.
  - HILO_Wait_Count: cycles with hilo_use=1.
  - All reset to 0 and stick at all-ones.
- Not defined: the ports and logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package holds:
  - forward encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - MDU state encoding IDLE/BUSY;
  - REG_ZERO=5'd0.
- One sub-module: forward_unit, purely combinational, instantiated twice (A and B).
- FSM, stall and flush logic stay in hazard_sequencer.

Test Plan:
- Forwarding: EX_MEM_Dest=8, EX_MEM_RegWrite=1, MEM_WB_Dest=8, MEM_WB_RegWrite=1, ID_EX_Rs=8 -> ForwardA=10. Drop EX_MEM_RegWrite -> 01. Set dest=0 -> 00.
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=9, IF_ID_Rs=9 -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 1 cycle. IF_ID_UsesRt=0 with IF_ID_Rt=9 only -> no stall.
- Branch priority: Branch_Taken=1 together with load_use -> all three flushes=1, PC_Write=1, ID_EX_Bubble=0.
- MDU timing: MDU_LATENCY=4, pulse ID_EX_MDU_Start -> HILO_Busy high 4 cycles, HILO_Write on 4th. mfhi in ID during cycles 1-3 stalls; released in cycle 4.
- Reset mid-operation: assert Reset_n=0 during BUSY with mdu_cnt=2 -> HILO_Busy=0 immediately, no HILO_Write after release.
- Stats (HAZARD_STATS_EN): 3 load-use stalls plus 2 branches -> Stall_Count=3, Flush_Count=2. Preload near max -> saturates at all-ones.
